uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL expose parameter pClksPerBit, default 104, meaning iClk cycles per UART bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 The module SHALL expose parameter pFifoDataWidth, default 8, meaning data bits per frame, matching the fifo read-data width.
REQ-003 iClk  input  1  system clock; all logic on its rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iFifoEmpty  input  1  high when the upstream fifo holds no data.
REQ-006 iFifoReadData  input  pFifoDataWidth  fifo read data, valid the cycle after oFifoReadEn is high.
REQ-007 oFifoReadEn  output  1  one-cycle pop request to the fifo.
REQ-008 oTx  output  1  UART serial line, idle high.
REQ-009 oBusy  output  1  high while a byte is being fetched or transmitted.
REQ-010 oTxDone  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-011 The block SHALL implement states IDLE, FETCH, LOAD, START, DATA, STOP.
REQ-012 In IDLE with iFifoEmpty=0, the block SHALL assert oFifoReadEn for exactly one cycle and enter FETCH.
REQ-013 In IDLE with iFifoEmpty=1, the block SHALL keep oFifoReadEn=0, oTx=1, oBusy=0.
REQ-014 FETCH SHALL last one cycle with oFifoReadEn=0, then go to LOAD.
REQ-015 LOAD SHALL capture iFifoReadData into the shift register, clear the bit counter and baud counter, and go to START.
REQ-016 oTx SHALL be driven from a register; it goes low on the first cycle of START, 3 cycles after the oFifoReadEn cycle (read, fetch, load).
REQ-017 START, each DATA bit, and STOP SHALL each hold oTx for exactly pClksPerBit cycles, timed by a baud counter running 0..pClksPerBit-1.
REQ-018 DATA SHALL transmit pFifoDataWidth bits LSB first, then enter STOP with oTx=1.
REQ-019 A full frame SHALL occupy (pFifoDataWidth+2)*pClksPerBit cycles of oTx, from the start-bit falling edge to the end of the stop bit.
REQ-020 On the last cycle of STOP, oTxDone SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-021 Back-to-back: if iFifoEmpty=0 in the IDLE cycle after STOP, the next oFifoReadEn SHALL occur in that cycle, giving an idle-high gap of exactly 3 cycles between frames.
REQ-022 oBusy SHALL be high in every state except IDLE.
REQ-023 iFifoEmpty and iFifoReadData SHALL be ignored outside IDLE and LOAD respectively; no second read is issued while busy.
REQ-024 The block SHALL never assert oFifoReadEn while iFifoEmpty=1.
REQ-025 Baud and bit counters SHALL be sized with $clog2 of their ranges and SHALL never wrap within a state.

Reset
REQ-026 With iRst=1 at a rising edge, the next cycle SHALL show state=IDLE, oTx=1, oFifoReadEn=0, oBusy=0, oTxDone=0, counters=0, shift register=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (oTx high the next cycle); the aborted byte is discarded and not re-read.
REQ-028 Reset in the oFifoReadEn cycle or in FETCH SHALL discard the popped byte; no frame starts.
REQ-029 After iRst deasserts, the block SHALL evaluate iFifoEmpty on the first cycle and may issue a read then.

Verification (pClksPerBit=4 unless noted)
REQ-030 fifo loaded with 0x55, iFifoEmpty falls -> one oFifoReadEn pulse; oTx starts 3 cycles later: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; oTxDone pulses on the last stop cycle; 40 cycles total.
REQ-031 iFifoEmpty held at 1 for 200 cycles after reset -> oFifoReadEn never asserts; oTx=1 and oBusy=0 throughout.
REQ-032 fifo holds 0xA5 then 0x3C -> two frames LSB first (A5: 1,0,1,0,0,1,0,1; 3C: 0,0,1,1,1,1,0,0) with exactly 3 idle-high cycles between the end of the first stop bit and the second start bit; exactly 2 read pulses.
REQ-033 iRst pulsed during data bit 3 of 0xFF -> oTx=1 the next cycle, oBusy=0; the next fifo byte is transmitted fully and correctly.
REQ-034 End-to-end with the fifo: write 32 bytes 0x01..0x20 into the fifo (depth 16; writes while oFifoFull=1 are dropped) -> the serial decoder receives the accepted bytes in write order, and the read count equals the accepted write count.
REQ-035 pClksPerBit=104 and byte 0x00 -> frame length is 1040 cycles; the start bit plus eight data bits hold oTx low for 936 consecutive cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter fed by an upstream fifo: pops one word, then sends start, data LSB first, and stop.
// Frame timing comes from a baud counter; the serial line is always driven from a register.
module uart_tx #(
  parameter int pClksPerBit    = 104,
  parameter int pFifoDataWidth = 8
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iFifoEmpty,
  input  logic [pFifoDataWidth-1:0] iFifoReadData,
  output logic                      oFifoReadEn,
  output logic                      oTx,
  output logic                      oBusy,
  output logic                      oTxDone
);

  localparam int pBaudW = (pClksPerBit > 1) ? $clog2(pClksPerBit) : 1;
  localparam int pBitW  = (pFifoDataWidth > 1) ? $clog2(pFifoDataWidth) : 1;
  localparam logic [pBaudW-1:0] cBaudLast = pBaudW'(pClksPerBit - 1);
  localparam logic [pBitW-1:0]  cBitLast  = pBitW'(pFifoDataWidth - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tState;

  tState                     stateR;
  tState                     stateNextS;
  logic [pBaudW-1:0]         baudCntR;
  logic [pBitW-1:0]          bitCntR;
  logic [pFifoDataWidth-1:0] shiftR;
  logic                      txR;
  logic                      baudLastS;
  logic                      bitLastS;

  assign baudLastS = (baudCntR == cBaudLast);
  assign bitLastS  = (bitCntR == cBitLast);
  assign oTx       = txR;

  // Next-state decode plus the fifo pop, busy and done strobes.
  always_comb begin
    stateNextS  = stateR;
    oFifoReadEn = 1'b0;
    oBusy       = 1'b1;
    oTxDone     = 1'b0;
    case (stateR)
      IDLE: begin
        oBusy = 1'b0;
        // Never pop while reset is held, so a word cannot be lost to a reset.
        if (!iFifoEmpty && !iRst) begin
          oFifoReadEn = 1'b1;
          stateNextS  = FETCH;
        end else begin
          stateNextS = IDLE;
        end
      end
      FETCH: stateNextS = LOAD;
      LOAD:  stateNextS = START;
      START: begin
        if (baudLastS) begin
          stateNextS = DATA;
        end else begin
          stateNextS = START;
        end
      end
      DATA: begin
        if (baudLastS && bitLastS) begin
          stateNextS = STOP;
        end else begin
          stateNextS = DATA;
        end
      end
      STOP: begin
        if (baudLastS) begin
          oTxDone    = 1'b1;
          stateNextS = IDLE;
        end else begin
          stateNextS = STOP;
        end
      end
      default: begin
        oBusy      = 1'b0;
        stateNextS = IDLE;
      end
    endcase
  end

  // State register, baud/bit counters, shift register and the registered line driver.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateR   <= IDLE;
      baudCntR <= {pBaudW{1'b0}};
      bitCntR  <= {pBitW{1'b0}};
      shiftR   <= {pFifoDataWidth{1'b0}};
      txR      <= 1'b1;
    end else begin
      stateR <= stateNextS;
      case (stateR)
        IDLE: begin
          baudCntR <= {pBaudW{1'b0}};
          bitCntR  <= {pBitW{1'b0}};
          txR      <= 1'b1;
        end
        FETCH: begin
          txR <= 1'b1;
        end
        LOAD: begin
          shiftR   <= iFifoReadData;
          baudCntR <= {pBaudW{1'b0}};
          bitCntR  <= {pBitW{1'b0}};
          txR      <= 1'b0;
        end
        START: begin
          if (baudLastS) begin
            baudCntR <= {pBaudW{1'b0}};
            txR      <= shiftR[0];
            shiftR   <= shiftR >> 1;
          end else begin
            baudCntR <= baudCntR + pBaudW'(1);
          end
        end
        DATA: begin
          if (baudLastS) begin
            baudCntR <= {pBaudW{1'b0}};
            if (bitLastS) begin
              bitCntR <= {pBitW{1'b0}};
              txR     <= 1'b1;
            end else begin
              bitCntR <= bitCntR + pBitW'(1);
              txR     <= shiftR[0];
              shiftR  <= shiftR >> 1;
            end
          end else begin
            baudCntR <= baudCntR + pBaudW'(1);
          end
        end
        STOP: begin
          if (baudLastS) begin
            baudCntR <= {pBaudW{1'b0}};
          end else begin
            baudCntR <= baudCntR + pBaudW'(1);
          end
        end
        default: begin
          txR <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a depth-16 fifo model feeds the DUT, accepted writes go to a scoreboard
// queue, and a cycle-accurate frame receiver pops and compares each transmitted byte.
module tb_uart_tx;
  localparam int cP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       fifoEmpty, dutRdEn, tx, busy, txDone;
  logic [7:0] fRdData = 8'h00;
  logic       empty104 = 1'b1;
  logic [7:0] data104 = 8'h00;
  logic       rdEn104, tx104, busy104, done104;

  logic [7:0] fMem [16];
  logic [3:0] fRp = 4'd0, fWp = 4'd0;
  int         fCount = 0;
  logic       wrEn = 1'b0;
  logic [7:0] wrData = 8'h00;
  logic       pushOk, popOk;

  int cyc = 0, readCount = 0, lastReadCyc = -1, badReads = 0, accepted = 0, readCount104 = 0;
  logic [7:0] expQ [$];
  int nChecks = 0, nFails = 0;

  uart_tx #(.pClksPerBit(cP), .pFifoDataWidth(8)) dut (
    .iClk(clk), .iRst(rst), .iFifoEmpty(fifoEmpty), .iFifoReadData(fRdData),
    .oFifoReadEn(dutRdEn), .oTx(tx), .oBusy(busy), .oTxDone(txDone));

  uart_tx #(.pClksPerBit(104), .pFifoDataWidth(8)) dut104 (
    .iClk(clk), .iRst(rst), .iFifoEmpty(empty104), .iFifoReadData(data104),
    .oFifoReadEn(rdEn104), .oTx(tx104), .oBusy(busy104), .oTxDone(done104));

  assign fifoEmpty = (fCount == 0);
  assign pushOk    = wrEn && (fCount != 16);
  assign popOk     = dutRdEn && (fCount != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (popOk) begin
      fRdData <= fMem[fRp];
      fRp     <= fRp + 4'd1;
    end
    if (pushOk) begin
      fMem[fWp] <= wrData;
      fWp       <= fWp + 4'd1;
      expQ.push_back(wrData);
      accepted  <= accepted + 1;
    end
    fCount <= fCount + (pushOk ? 1 : 0) - (popOk ? 1 : 0);
    if (dutRdEn) begin
      readCount   <= readCount + 1;
      lastReadCyc <= cyc;
    end
    if (dutRdEn && fifoEmpty) badReads <= badReads + 1;
    if (rdEn104) readCount104 <= readCount104 + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Receives one frame on the 4-clock DUT; status 0 = good, 1 = no start bit, 2 = malformed.
  task automatic recvFrame(input int maxWait, output logic [7:0] data, output int startCyc,
                           output int doneCyc, output int status);
    int   w = 0;
    bit   bad = 1'b0;
    logic bitVal = 1'b1;
    data = 8'h00; startCyc = -1; doneCyc = -1;
    while (tx !== 1'b0 && w < maxWait) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      status = 1;
    end else begin
      startCyc = cyc;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < cP; c++) begin
          if (c == 0) begin
            if (k == 0) bitVal = 1'b0;
            else if (k == 9) bitVal = 1'b1;
            else begin
              bitVal = tx;
              data[k-1] = tx;
            end
          end
          if (tx !== bitVal) bad = 1'b1;
          if (busy !== 1'b1 || dutRdEn !== 1'b0) bad = 1'b1;
          if (txDone !== ((k == 9 && c == cP - 1) ? 1'b1 : 1'b0)) bad = 1'b1;
          if (k == 9 && c == cP - 1) doneCyc = cyc;
          else @(negedge clk);
        end
      end
      status = bad ? 2 : 0;
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    wrEn = 1'b1; wrData = b;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    int s, dn, st;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nChecks++; if (tx !== 1'b1) begin nFails++; $display("FAIL reset_tx: got %b required 1", tx); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL reset_busy: got %b required 0", busy); end
    nChecks++; if (txDone !== 1'b0) begin nFails++; $display("FAIL reset_done: got %b required 0", txDone); end
    nChecks++; if (tx104 !== 1'b1 || busy104 !== 1'b0) begin nFails++; $display("FAIL reset_dut104: got tx=%b busy=%b required 1/0", tx104, busy104); end
    pushByte(8'h5A);
    nChecks++; if (dutRdEn !== 1'b0) begin nFails++; $display("FAIL reset_no_pop: got %b required 0", dutRdEn); end
    rst = 1'b0;
    recvFrame(50, d, s, dn, st);
    nChecks++; if (st != 0) begin nFails++; $display("FAIL reset_first_frame: got status %0d required 0", st); end
    e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (d !== e) begin nFails++; $display("FAIL reset_first_data: got %h required %h", d, e); end
    nChecks++; if (s - lastReadCyc != 3) begin nFails++; $display("FAIL reset_first_latency: got %0d required 3", s - lastReadCyc); end
    nChecks++; if (readCount != 1) begin nFails++; $display("FAIL reset_read_count: got %0d required 1", readCount); end
  endtask

  task automatic test_single();
    logic [7:0] d, e;
    int s, dn, st, r0;
    repeat (3) @(negedge clk);
    r0 = readCount;
    pushByte(8'h55);
    recvFrame(50, d, s, dn, st);
    nChecks++; if (st != 0) begin nFails++; $display("FAIL single_frame: got status %0d required 0", st); end
    e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (d !== e || d !== 8'h55) begin nFails++; $display("FAIL single_data: got %h required %h", d, e); end
    nChecks++; if (s - lastReadCyc != 3) begin nFails++; $display("FAIL single_latency: got %0d required 3", s - lastReadCyc); end
    nChecks++; if (dn - s + 1 != 40) begin nFails++; $display("FAIL single_length: got %0d required 40", dn - s + 1); end
    @(negedge clk);
    nChecks++; if (busy !== 1'b0 || tx !== 1'b1) begin nFails++; $display("FAIL single_idle_after: got busy=%b tx=%b required 0/1", busy, tx); end
    nChecks++; if (readCount - r0 != 1) begin nFails++; $display("FAIL single_reads: got %0d required 1", readCount - r0); end
  endtask

  task automatic test_idle_empty();
    int bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dutRdEn !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    nChecks++; if (bad != 0) begin nFails++; $display("FAIL idle_empty: got %0d bad cycles required 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2, e1, e2;
    int s1, dn1, st1, s2, dn2, st2, r0;
    r0 = readCount;
    wrEn = 1'b1; wrData = 8'hA5;
    @(negedge clk);
    wrData = 8'h3C;
    @(negedge clk);
    wrEn = 1'b0;
    recvFrame(50, d1, s1, dn1, st1);
    recvFrame(50, d2, s2, dn2, st2);
    e1 = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    e2 = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (st1 != 0 || st2 != 0) begin nFails++; $display("FAIL b2b_frames: got status %0d/%0d required 0/0", st1, st2); end
    nChecks++; if (d1 !== e1 || d1 !== 8'hA5) begin nFails++; $display("FAIL b2b_data1: got %h required %h", d1, e1); end
    nChecks++; if (d2 !== e2 || d2 !== 8'h3C) begin nFails++; $display("FAIL b2b_data2: got %h required %h", d2, e2); end
    nChecks++; if (s2 - dn1 - 1 != 3) begin nFails++; $display("FAIL b2b_gap: got %0d required 3", s2 - dn1 - 1); end
    nChecks++; if (readCount - r0 != 2) begin nFails++; $display("FAIL b2b_reads: got %0d required 2", readCount - r0); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d, e;
    int s, dn, st, r0, w = 0, bad = 0;
    pushByte(8'hFF);
    while (tx !== 1'b0 && w < 50) begin @(negedge clk); w++; end
    nChecks++; if (tx !== 1'b0) begin nFails++; $display("FAIL midrst_start: got tx=%b required 0", tx); end
    repeat (4 * cP + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nChecks++; if (tx !== 1'b1 || busy !== 1'b0) begin nFails++; $display("FAIL midrst_abort: got tx=%b busy=%b required 1/0", tx, busy); end
    rst = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_front());
    r0 = readCount;
    for (int i = 0; i < 3 * cP; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    nChecks++; if (bad != 0 || readCount != r0) begin nFails++; $display("FAIL midrst_quiet: got %0d bad cycles, %0d reads required 0/0", bad, readCount - r0); end
    pushByte(8'h96);
    recvFrame(50, d, s, dn, st);
    e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (st != 0 || d !== e) begin nFails++; $display("FAIL midrst_next: got %h status %0d required %h status 0", d, st, e); end
  endtask

  task automatic test_reset_in_fetch();
    int w = 0, bad = 0, r0;
    pushByte(8'hC3);
    while (dutRdEn !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    nChecks++; if (dutRdEn !== 1'b1) begin nFails++; $display("FAIL fetchrst_pop: got %b required 1", dutRdEn); end
    @(negedge clk);
    nChecks++; if (busy !== 1'b1 || tx !== 1'b1) begin nFails++; $display("FAIL fetchrst_fetch: got busy=%b tx=%b required 1/1", busy, tx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_front());
    r0 = readCount;
    for (int i = 0; i < 5 * cP; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    nChecks++; if (bad != 0 || readCount != r0) begin nFails++; $display("FAIL fetchrst_discard: got %0d bad cycles, %0d reads required 0/0", bad, readCount - r0); end
  endtask

  task automatic test_fifo_e2e();
    int a0, r0, frames = 0, dataBad = 0, st, s, dn;
    logic [7:0] d, e;
    a0 = accepted; r0 = readCount;
    fork
      begin
        for (int i = 1; i <= 32; i++) begin
          wrEn = 1'b1; wrData = 8'(i);
          @(negedge clk);
        end
        wrEn = 1'b0;
      end
      begin
        st = 0;
        while (st != 1 && frames < 40) begin
          recvFrame(200, d, s, dn, st);
          if (st != 1) begin
            frames++;
            e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
            if (st != 0 || d !== e) begin
              dataBad++;
              $display("FAIL e2e_frame %0d: got %h status %0d required %h", frames, d, st, e);
            end
          end
        end
      end
    join
    nChecks++; if (dataBad != 0) begin nFails++; $display("FAIL e2e_data: got %0d bad frames required 0", dataBad); end
    nChecks++; if (frames != accepted - a0 || frames < 16) begin nFails++; $display("FAIL e2e_frames: got %0d required %0d", frames, accepted - a0); end
    nChecks++; if (readCount - r0 != accepted - a0) begin nFails++; $display("FAIL e2e_reads: got %0d required %0d", readCount - r0, accepted - a0); end
    nChecks++; if (badReads != 0 || expQ.size() != 0) begin nFails++; $display("FAIL e2e_leftover: got %0d empty-reads, %0d queued required 0/0", badReads, expQ.size()); end
  endtask

  task automatic test_long_frame();
    int w = 0, lowCount = 0, s, dn;
    empty104 = 1'b0;
    @(negedge clk);
    empty104 = 1'b1;
    while (tx104 !== 1'b0 && w < 20) begin @(negedge clk); w++; end
    s = cyc;
    while (tx104 === 1'b0 && lowCount < 2000) begin lowCount++; @(negedge clk); end
    w = 0;
    while (done104 !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
    dn = cyc;
    nChecks++; if (lowCount != 936) begin nFails++; $display("FAIL long_low: got %0d required 936", lowCount); end
    nChecks++; if (done104 !== 1'b1 || dn - s + 1 != 1040) begin nFails++; $display("FAIL long_length: got %0d required 1040", dn - s + 1); end
    @(negedge clk);
    nChecks++; if (readCount104 != 1 || busy104 !== 1'b0) begin nFails++; $display("FAIL long_reads: got %0d reads busy=%b required 1/0", readCount104, busy104); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle_empty();
    test_back_to_back();
    test_reset_midframe();
    test_reset_in_fetch();
    test_fifo_e2e();
    test_long_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
